// File: rtl/led_sequencer.sv
// Four independently scheduled active-low LEDs (OFF / ON / BLINK / counted FLASH)
// sharing one tick prescaler. Define LED_SEQ_DIM_EN to add per-LED PWM dimming.
module led_sequencer #(
    parameter int CLK_HZ  = 25000000,
    parameter int TICK_HZ = 1000
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_led,
    input  logic [1:0]  cmd_mode,
    input  logic [15:0] cmd_period,
    input  logic [3:0]  cmd_count,
`ifdef LED_SEQ_DIM_EN
    input  logic [3:0]  cmd_level,
`endif
    output logic [3:0]  busy,
    output logic [3:0]  done,
    output logic [3:0]  led
);

    localparam int DIV = CLK_HZ / TICK_HZ;
    localparam int PW  = $clog2(DIV);

    localparam logic [1:0] MODE_OFF   = 2'd0;
    localparam logic [1:0] MODE_ON    = 2'd1;
    localparam logic [1:0] MODE_BLINK = 2'd2;
    localparam logic [1:0] MODE_FLASH = 2'd3;

    typedef enum logic [1:0] {
        IDLE_OFF = 2'd0,
        IDLE_ON  = 2'd1,
        PH_ON    = 2'd2,
        PH_OFF   = 2'd3
    } led_state_t;

    logic [PW-1:0] presc_reg;
    logic          tick;
    logic          cmd_fire;

    assign cmd_ready = resetn;
    assign cmd_fire  = cmd_valid & resetn;
    assign tick      = (presc_reg == PW'(DIV - 1));

    // Free-running timebase; commands never disturb its phase.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            presc_reg <= '0;
        end else if (tick) begin
            presc_reg <= '0;
        end else begin
            presc_reg <= presc_reg + PW'(1);
        end
    end

`ifdef LED_SEQ_DIM_EN
    logic [3:0] pwm_reg;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pwm_reg <= '0;
        end else begin
            pwm_reg <= pwm_reg + 4'd1;
        end
    end
`endif

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_led
            led_state_t  state_reg, state_next;
            logic [15:0] timer_reg, timer_next;
            logic [15:0] period_reg, period_next;
            logic [3:0]  pulses_reg, pulses_next;
            logic        flash_reg, flash_next;
            logic        done_reg, done_next;
            logic        hit;
            logic        lit;
            logic [15:0] period_sat;

            assign hit        = cmd_fire && (cmd_led == 2'(gi));
            assign period_sat = (cmd_period == 16'd0) ? 16'd1 : cmd_period;

`ifdef LED_SEQ_DIM_EN
            logic [3:0] level_reg, level_next;
            assign lit = (pwm_reg <= level_reg);
`else
            assign lit = 1'b1;
`endif

            always_ff @(posedge clk or negedge resetn) begin
                if (!resetn) begin
                    state_reg  <= IDLE_OFF;
                    timer_reg  <= '0;
                    period_reg <= '0;
                    pulses_reg <= '0;
                    flash_reg  <= 1'b0;
                    done_reg   <= 1'b0;
`ifdef LED_SEQ_DIM_EN
                    level_reg  <= '0;
`endif
                end else begin
                    state_reg  <= state_next;
                    timer_reg  <= timer_next;
                    period_reg <= period_next;
                    pulses_reg <= pulses_next;
                    flash_reg  <= flash_next;
                    done_reg   <= done_next;
`ifdef LED_SEQ_DIM_EN
                    level_reg  <= level_next;
`endif
                end
            end

            // A command for this LED takes priority over a coincident phase-end tick.
            always_comb begin
                state_next  = state_reg;
                timer_next  = timer_reg;
                period_next = period_reg;
                pulses_next = pulses_reg;
                flash_next  = flash_reg;
                done_next   = 1'b0;
`ifdef LED_SEQ_DIM_EN
                level_next  = level_reg;
`endif
                if (hit) begin
                    period_next = period_sat;
                    timer_next  = period_sat;
                    pulses_next = cmd_count;
                    flash_next  = (cmd_mode == MODE_FLASH);
`ifdef LED_SEQ_DIM_EN
                    level_next  = cmd_level;
`endif
                    case (cmd_mode)
                        MODE_OFF:   state_next = IDLE_OFF;
                        MODE_ON:    state_next = IDLE_ON;
                        MODE_BLINK: state_next = PH_ON;
                        default:    state_next = (cmd_count == 4'd0) ? IDLE_OFF : PH_ON;
                    endcase
                end else if (tick && ((state_reg == PH_ON) || (state_reg == PH_OFF))) begin
                    if (timer_reg == 16'd1) begin
                        timer_next = period_reg;
                        if (state_reg == PH_ON) begin
                            state_next = PH_OFF;
                        end else if (!flash_reg) begin
                            state_next = PH_ON;
                        end else if (pulses_reg == 4'd1) begin
                            pulses_next = 4'd0;
                            state_next  = IDLE_OFF;
                            done_next   = 1'b1;
                        end else begin
                            pulses_next = pulses_reg - 4'd1;
                            state_next  = PH_ON;
                        end
                    end else begin
                        timer_next = timer_reg - 16'd1;
                    end
                end
            end

            assign busy[gi] = (state_reg == PH_ON) || (state_reg == PH_OFF);
            assign done[gi] = done_reg;
            assign led[gi]  = ~(((state_reg == IDLE_ON) || (state_reg == PH_ON)) && lit);
        end
    endgenerate

endmodule

// File: tb/tb_led_sequencer.sv
// Bench for led_sequencer: directed scenarios plus randomized commands checked
// against a tick-count reference model (10 clk per tick).
module tb_led_sequencer;

    localparam int DIV = 10;

    logic        clk = 1'b0;
    logic        resetn;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_led;
    logic [1:0]  cmd_mode;
    logic [15:0] cmd_period;
    logic [3:0]  cmd_count;
`ifdef LED_SEQ_DIM_EN
    logic [3:0]  cmd_level;
`endif
    logic [3:0]  busy;
    logic [3:0]  done;
    logic [3:0]  led;

    always #5 clk = ~clk;

    led_sequencer #(.CLK_HZ(1000), .TICK_HZ(100)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_led    (cmd_led),
        .cmd_mode   (cmd_mode),
        .cmd_period (cmd_period),
        .cmd_count  (cmd_count),
`ifdef LED_SEQ_DIM_EN
        .cmd_level  (cmd_level),
`endif
        .busy       (busy),
        .done       (done),
        .led        (led)
    );

    int checks = 0;
    int errors = 0;
    int edge_n = 0;
    bit chk_en = 1'b1;

    // Model: per LED, the last accepted command and the edge it was accepted on.
    int m_mode[4];
    int m_acc[4];
    int m_per[4];
    int m_cnt[4];

    task automatic model_reset();
        edge_n = 0;
        for (int i = 0; i < 4; i++) begin
            m_mode[i] = 0;
            m_acc[i]  = 0;
            m_per[i]  = 1;
            m_cnt[i]  = 0;
        end
    endtask

    task automatic send(input int l, input int m, input int per, input int cnt);
        cmd_valid  = 1'b1;
        cmd_led    = 2'(l);
        cmd_mode   = 2'(m);
        cmd_period = 16'(per);
        cmd_count  = 4'(cnt);
        $display("cmd edge=%0d led=%0d mode=%0d period=%0d count=%0d", edge_n + 1, l, m, per, cnt);
    endtask

    // One clock: record any accepted command, then compare all outputs at the negedge.
    task automatic cycle();
        logic [3:0] e_led, e_busy, e_done;
        int k, p, c;
        @(posedge clk);
        edge_n++;
        if (cmd_valid) begin
            m_mode[cmd_led] = int'(cmd_mode);
            m_acc[cmd_led]  = edge_n;
            m_per[cmd_led]  = (cmd_period == 16'd0) ? 1 : int'(cmd_period);
            m_cnt[cmd_led]  = int'(cmd_count);
        end
        @(negedge clk);
        cmd_valid = 1'b0;
        e_led  = 4'hf;
        e_busy = 4'h0;
        e_done = 4'h0;
        for (int i = 0; i < 4; i++) begin
            k = edge_n / DIV - m_acc[i] / DIV;
            p = m_per[i];
            c = m_cnt[i];
            case (m_mode[i])
                1: e_led[i] = 1'b0;
                2: begin
                    e_busy[i] = 1'b1;
                    e_led[i]  = ((k / p) % 2) == 1;
                end
                3: if (c != 0) begin
                    if (k < 2 * c * p) begin
                        e_busy[i] = 1'b1;
                        e_led[i]  = ((k / p) % 2) == 1;
                    end else if (k == 2 * c * p && edge_n % DIV == 0) begin
                        e_done[i] = 1'b1;
                    end
                end
                default: ;
            endcase
        end
        if (chk_en) begin
            checks++;
            if (led !== e_led) begin
                errors++;
                $display("FAIL model_led edge=%0d got %b expected %b", edge_n, led, e_led);
            end
            checks++;
            if (busy !== e_busy) begin
                errors++;
                $display("FAIL model_busy edge=%0d got %b expected %b", edge_n, busy, e_busy);
            end
            checks++;
            if (done !== e_done) begin
                errors++;
                $display("FAIL model_done edge=%0d got %b expected %b", edge_n, done, e_done);
            end
        end
    endtask

    task automatic test_reset();
        resetn     = 1'b0;
        cmd_valid  = 1'b0;
        cmd_led    = 2'd0;
        cmd_mode   = 2'd0;
        cmd_period = 16'd0;
        cmd_count  = 4'd0;
`ifdef LED_SEQ_DIM_EN
        cmd_level  = 4'd15;
`endif
        #2;
        checks++;
        if ({led, busy, done, cmd_ready} !== {4'b1111, 4'b0000, 4'b0000, 1'b0}) begin
            errors++;
            $display("FAIL reset_values got led=%b busy=%b done=%b ready=%b expected 1111/0000/0000/0",
                     led, busy, done, cmd_ready);
        end
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        model_reset();
        #1;
        checks++;
        if (cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL ready_after_reset got %b expected 1", cmd_ready);
        end
        repeat (5) cycle();
    endtask

    task automatic test_on_off();
        send(2, 1, 0, 0);
        cycle();
        checks++;
        if (led !== 4'b1011) begin
            errors++;
            $display("FAIL on_led2 got %b expected 1011", led);
        end
        send(2, 0, 0, 0);
        cycle();
        checks++;
        if ({led, busy, done} !== {4'b1111, 4'b0000, 4'b0000}) begin
            errors++;
            $display("FAIL off_led2 got led=%b busy=%b done=%b expected 1111/0000/0000", led, busy, done);
        end
        repeat (3) cycle();
    endtask

    task automatic test_flash();
        int runs[$];
        int cur = 0;
        int dones = 0;
        logic prev_busy = 1'b0;
        send(0, 3, 3, 2);
        for (int n = 0; n < 130; n++) begin
            cycle();
            if (led[0] == 1'b0) begin
                cur++;
            end else if (cur > 0) begin
                runs.push_back(cur);
                cur = 0;
            end
            if (done[0]) begin
                dones++;
                checks++;
                if (!(busy[0] === 1'b0 && prev_busy === 1'b1)) begin
                    errors++;
                    $display("FAIL flash_busy_fall got busy=%b prev=%b expected 0 prev 1", busy[0], prev_busy);
                end
            end
            prev_busy = busy[0];
        end
        checks++;
        if (runs.size() != 2) begin
            errors++;
            $display("FAIL flash_runs got %0d lit runs expected 2", runs.size());
        end else begin
            checks++;
            if (runs[0] < 20 || runs[0] > 30) begin
                errors++;
                $display("FAIL flash_first_run got %0d clk expected 20..30", runs[0]);
            end
            checks++;
            if (runs[1] != 30) begin
                errors++;
                $display("FAIL flash_second_run got %0d clk expected 30", runs[1]);
            end
        end
        checks++;
        if (dones != 1) begin
            errors++;
            $display("FAIL flash_done_count got %0d expected 1", dones);
        end
    endtask

    task automatic test_blink();
        int toggles = 0;
        int not_busy = 0;
        logic prev;
        send(1, 2, 0, 0);
        cycle();
        prev = led[1];
        for (int n = 0; n < 60; n++) begin
            cycle();
            if (led[1] !== prev) toggles++;
            if (busy[1] !== 1'b1) not_busy++;
            prev = led[1];
        end
        checks++;
        if (toggles < 5 || not_busy != 0) begin
            errors++;
            $display("FAIL blink_activity got toggles=%0d not_busy=%0d expected >=5 and 0", toggles, not_busy);
        end
        send(1, 0, 0, 0);
        cycle();
        checks++;
        if ({led[1], busy[1]} !== 2'b10) begin
            errors++;
            $display("FAIL blink_stop got led=%b busy=%b expected 1/0", led[1], busy[1]);
        end
    endtask

    task automatic test_reflash();
        int dones = 0;
        send(3, 3, 2, 5);
        for (int n = 0; n < 25; n++) begin
            cycle();
            if (done[3]) dones++;
        end
        send(3, 3, 2, 1);
        for (int n = 0; n < 60; n++) begin
            cycle();
            if (done[3]) dones++;
        end
        checks++;
        if (dones != 1 || led[3] !== 1'b1 || busy[3] !== 1'b0) begin
            errors++;
            $display("FAIL reflash got dones=%0d led=%b busy=%b expected 1/1/0", dones, led[3], busy[3]);
        end
    endtask

    task automatic test_back_to_back();
        for (int j = 0; j < 8; j++) begin
            send(j % 4, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
            cycle();
        end
        repeat (100) cycle();
    endtask

    task automatic test_random();
        for (int n = 0; n < 800; n++) begin
            if ($urandom_range(0, 3) == 0) begin
                send(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                     int'($urandom_range(0, 4)), int'($urandom_range(0, 3)));
            end
            cycle();
        end
    endtask

    task automatic test_mid_reset();
        send(0, 3, 3, 2);
        cycle();
        send(1, 2, 1, 0);
        repeat (25) cycle();
        #2;
        resetn = 1'b0;
        #1;
        checks++;
        if ({led, busy, done, cmd_ready} !== {4'b1111, 4'b0000, 4'b0000, 1'b0}) begin
            errors++;
            $display("FAIL async_reset got led=%b busy=%b done=%b ready=%b expected 1111/0000/0000/0",
                     led, busy, done, cmd_ready);
        end
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        model_reset();
        repeat (150) cycle();
    endtask

`ifdef LED_SEQ_DIM_EN
    task automatic test_dim();
        int lit = 0;
        chk_en = 1'b0;
        cmd_level = 4'd3;
        send(0, 1, 0, 0);
        cycle();
        cmd_level = 4'd15;
        for (int n = 0; n < 16; n++) begin
            cycle();
            if (led[0] == 1'b0) lit++;
        end
        checks++;
        if (lit != 4) begin
            errors++;
            $display("FAIL dim_duty got %0d lit of 16 expected 4", lit);
        end
        send(0, 0, 0, 0);
        cycle();
        chk_en = 1'b1;
        repeat (3) cycle();
    endtask
`endif

    initial begin
        test_reset();
        test_on_off();
        test_flash();
        test_blink();
        test_reflash();
        test_back_to_back();
        test_random();
`ifdef LED_SEQ_DIM_EN
        test_dim();
`endif
        test_mid_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/led_sequencer.md
# led_sequencer

Command-driven controller for the board's four active-low user LEDs, sitting between the top level and the LED pins. It replaces hard-wired LED constants and free-running blinkers. Each LED is scheduled independently as OFF, ON, continuous BLINK or counted FLASH from one shared millisecond-tick prescaler. Commands arrive over a valid/ready handshake, and one-cycle completion pulses are reported per LED.

## Interface
- CLK_HZ, 25000000, input clock frequency
- TICK_HZ, 1000, timebase tick rate; prescaler divide = CLK_HZ/TICK_HZ (integer, ≥2)
- clk  in  1  system clock (25 MHz)
- resetn  in  1  reset; one clock; reset is asynchronous and active-low
- cmd_valid  in  1  command present
- cmd_ready  out  1  command accepted when cmd_valid & cmd_ready
- cmd_led  in  2  target LED index 0..3
- cmd_mode  in  2  0 OFF, 1 ON, 2 BLINK, 3 FLASH
- cmd_period  in  16  half-period in ticks; 0 treated as 1
- cmd_count  in  4  FLASH pulse count
- busy  out  4  per-LED: mode BLINK, or FLASH still running
- done  out  4  per-LED one-cycle pulse when FLASH completes
- led  out  4  LED drive, active low (0 = lit)

## Operation
- Prescaler counts 0..CLK_HZ/TICK_HZ-1. `tick` is a one-cycle pulse on wrap. It is free-running and never reset by commands.
- Per-LED FSM states: IDLE_OFF, IDLE_ON, PH_ON, PH_OFF. Each LED has a 16-bit timer and a 4-bit pulse counter.
- Accept, registered and applied on the cycle after the handshake:
  - OFF → IDLE_OFF.
  - ON → IDLE_ON.
  - BLINK or FLASH → PH_ON, with timer = max(cmd_period, 1) and pulses = cmd_count.
  - FLASH with cmd_count = 0 → IDLE_OFF, with no done pulse.
- PH_ON/PH_OFF: timer decrements on tick. At tick with timer = 1, the phase ends and the timer reloads with the stored period.
  - PH_ON → PH_OFF.
  - PH_OFF in BLINK → PH_ON, repeating forever.
  - PH_OFF in FLASH: decrement pulses. If the result is 0 → IDLE_OFF and done pulses for 1 cycle. Otherwise → PH_ON.
- A new command to a LED in any state replaces that LED's operation immediately. The pending FLASH is aborted with no done pulse. Other LEDs are unaffected.
- cmd_ready = 1 whenever resetn is high; the block never back-pressures. Commands on consecutive cycles are all accepted.
- led[i] = 0 in IDLE_ON and PH_ON, and 1 in IDLE_OFF and PH_OFF.
- busy[i] = 1 in PH_ON/PH_OFF.

## Timing
- Reset values, asynchronous on resetn low:
  - led = 4'b1111, busy = 0, done = 0, cmd_ready = 0.
  - All FSMs IDLE_OFF; prescaler, timers and counters 0.
- Command latency: led/busy reflect an accepted command exactly 1 clk after the handshake cycle.
- First phase after accept lasts between (period-1) and period ticks, depending on prescaler phase. Every later phase lasts exactly period ticks, i.e. period·CLK_HZ/TICK_HZ cycles.
- done[i] asserts in the same cycle led[i] settles at its final IDLE_OFF value, for exactly 1 clk.
- A command accepted in the same cycle as that LED's phase-end tick wins; the tick is ignored for that LED.
- Reset asserted mid-FLASH: outputs go to reset values with no done pulse. Operation resumes only after the next command.

## Configuration
- LED_SEQ_DIM_EN defined:
  - Adds input cmd_level[3:0], latched per LED on accept, and a free-running 4-bit PWM counter on clk.
  - In IDLE_ON/PH_ON, an LED is lit only while pwm_cnt ≤ level. 15 = full, 0 = 1/16 duty.
  - The OFF behaviour is unchanged.
- LED_SEQ_DIM_EN not defined: there is no cmd_level port and no PWM logic; ON states are fully lit.

## Test plan
- Bench settings: CLK_HZ=1000, TICK_HZ=100 (10 clk/tick).
- Reset then idle: led=4'b1111, busy=0, cmd_ready=1 after resetn release. Assert resetn low mid-run: led returns to 4'b1111 asynchronously.
- ON LED2, then OFF LED2 on the next cycle: led=4'b1011 for 1 clk, then 4'b1111. No done, busy stays 0.
- FLASH LED0, period=3, count=2: two lit periods of 30 clk each, with the first ≥20 clk. done[0] pulses once, when the second off phase ends. busy[0] falls in the same cycle.
- BLINK LED1, period=0: toggles every tick (10 clk). busy[1]=1 indefinitely. An OFF command stops it 1 clk after accept.
- FLASH LED3, count=5, re-commanded with FLASH count=1 mid-run: no done from the first command, exactly one done after one further pulse.
- With LED_SEQ_DIM_EN, ON LED0, level=3: LED0 lit 4 of every 16 clk.
